nonce_buffer: RTL
=================

# nonce_buffer

Receiving end of the miner's result stream: consumes the per-cycle `resultValid` / `success` / `newBlock` outputs, numbers every result with a running nonce, and queues the nonces of successful hashes in a FIFO. A host-side drain port empties the FIFO with a valid/ready handshake. Stale nonces are discarded when a new block starts, and an overflow flag records lost successes for the current block.

## Interface
- `LOGDEPTH`, default 3: FIFO depth is 2^LOGDEPTH entries.
- `NONCEBITS`, default 32: nonce width; the nonce counter wraps modulo 2^NONCEBITS.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `resultValid`  in  1  miner result present this cycle.
- `success`  in  1  result met difficulty; qualified by `resultValid`.
- `newBlock`  in  1  result is the first of a new block; qualified by `resultValid`.
- `outValid`  out  1  FIFO non-empty; `outNonce` is meaningful.
- `outReady`  in  1  host accepts the head entry this cycle.
- `outNonce`  out  NONCEBITS  nonce at the FIFO head; 0 when empty.
- `overflow`  out  1  sticky: a success was dropped since the last new block or reset.
- `count`  out  LOGDEPTH+1  current FIFO occupancy, 0..2^LOGDEPTH.

## Operation
- Nonce numbering uses internal counter `nc`:
  - A result with `newBlock=1` carries nonce 0.
  - Any other valid result carries `nc`.
  - After each valid result, `nc` becomes (carried nonce + 1) mod 2^NONCEBITS.
  - `nc` does not change when `resultValid=0`.
- Push: `resultValid & success` writes the carried nonce at the write pointer.
- Pop: `outValid & outReady` advances the read pointer.
- Flush: `resultValid & newBlock` empties the FIFO (pointers and `count` to 0) and clears `overflow`.
  - Any pop in the same cycle is void: the host's accepted value is discarded with the rest.
  - A push in the same cycle is applied after the flush, so the result is `count=1`, head nonce 0.
- Full, push without pop: the push is dropped, `overflow` is set, and the contents are unchanged.
- Full, push with pop: both take effect, `count` stays 2^LOGDEPTH, and `overflow` is not set.
- Empty with `outReady=1`: no effect.
- Pointers are LOGDEPTH bits and wrap naturally. `count` is the occupancy tracked explicitly; full means `count == 2^LOGDEPTH`.
- Storage is registers and is not reset. Only pointers, `count`, `nc` and `overflow` are reset.

## Timing
- Reset (`rst=0`, asynchronous): `outValid=0`, `outNonce=0`, `overflow=0`, `count=0`, `nc=0`.
- Reset mid-operation discards all queued nonces immediately. The first result after reset without `newBlock` carries nonce 0.
- Push-to-visible latency is 1 cycle: a push on edge N gives `outValid=1` and `outNonce` = that nonce after edge N.
- `outValid`, `overflow` and `count` are functions of registered state only. No combinational path exists from `outReady` to `outValid`/`outNonce`.
- `outNonce` is combinational from the head register, gated to 0 when empty.
- Sustained throughput is one push and one pop per cycle.
- `overflow` is set the cycle after a dropped push. It stays set until reset or the next flush.

## Test plan
- Basic order: reset, then 5 valid results (first with `newBlock`), with `success` on results 1 and 3, and `outReady=0`.
  - Required: `count=2`, head=1.
  - Then `outReady=1` for 2 cycles. Required: pops yield 1 then 3, then `outValid=0` and `outNonce=0`.
- Fill and overflow (LOGDEPTH=3): 9 consecutive successes after a new block, no pops.
  - Required: `count=8`, nonces 0..7 queued, `overflow=1` one cycle after the 9th.
  - Nonce 8 is lost; `nc=9`.
- Full with simultaneous push and pop: FIFO full (0..7), then success plus `outReady`.
  - Required: 0 is popped, 8 is pushed, `count=8`, `overflow` stays 0.
- Flush with simultaneous push: 3 queued nonces and `overflow=1`, then a result with `newBlock=1`, `success=1`, `outReady=1`.
  - Required: `count=1`, head=0, `overflow=0`.
- Nonce wrap (NONCEBITS=4): 17 results with `success` on all, draining continuously.
  - Required: the drained sequence is 0..15, 0.
- Reset mid-operation: assert `rst=0` with 4 queued nonces, between clock edges.
  - Required: `outValid=0`, `count=0` and `overflow=0` immediately.
  - After release, a success without `newBlock` queues nonce 0.

Source files
------------

// File: rtl/nonce_buffer.sv
// Result-stream receiver for the miner: numbers every result with a running nonce
// and queues the nonces of successful hashes in a FIFO drained by a valid/ready port.
module nonce_buffer #(
    parameter int LOGDEPTH  = 3,
    parameter int NONCEBITS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 resultValid,
    input  logic                 success,
    input  logic                 newBlock,
    output logic                 outValid,
    input  logic                 outReady,
    output logic [NONCEBITS-1:0] outNonce,
    output logic                 overflow,
    output logic [LOGDEPTH:0]    count
);

    localparam int DEPTH = 1 << LOGDEPTH;
    localparam logic [LOGDEPTH:0] FULL_COUNT = (LOGDEPTH + 1)'(DEPTH);

    logic [NONCEBITS-1:0] mem [DEPTH];
    logic [LOGDEPTH-1:0]  wr_ptr;
    logic [LOGDEPTH-1:0]  rd_ptr;
    logic [LOGDEPTH-1:0]  wr_idx;
    logic [NONCEBITS-1:0] nc;
    logic [NONCEBITS-1:0] carried;
    logic                 flush;
    logic                 push;
    logic                 do_push;
    logic                 do_pop;
    logic                 full;

    // A flush voids any same-cycle pop and leaves room, so a flushing push always lands in slot 0.
    always_comb begin
        carried = newBlock ? '0 : nc;
        flush   = resultValid & newBlock;
        push    = resultValid & success;
        full    = (count == FULL_COUNT);
        do_pop  = outValid & outReady & ~flush;
        do_push = push & (flush | ~full | do_pop);
        wr_idx  = flush ? '0 : wr_ptr;
    end

    assign outValid = (count != '0);
    assign outNonce = outValid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= carried;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            nc       <= '0;
            overflow <= 1'b0;
        end else begin
            if (resultValid) begin
                nc <= carried + 1'b1;
            end
            if (flush) begin
                rd_ptr   <= '0;
                wr_ptr   <= do_push ? LOGDEPTH'(1) : '0;
                count    <= do_push ? (LOGDEPTH + 1)'(1) : '0;
                overflow <= 1'b0;
            end else begin
                if (do_push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({do_push, do_pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
                if (push && !do_push) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule
